// File: rtl/reduce_pipe_pkg.sv
// Shared types for the lane-reduction pipeline: reduction operator encoding.
// RED_RSVD is decoded as AND so a stray mode never produces an undefined result.
package reduce_pipe_pkg;

   typedef enum logic [1:0] {
      RED_AND  = 2'b00,
      RED_OR   = 2'b01,
      RED_XOR  = 2'b10,
      RED_RSVD = 2'b11
   } red_mode_t;

endpackage

// File: rtl/reduce_pipe_if.sv
// Producer/consumer handshake bundle for reduce_pipe: lane-parallel input beat, reduced output beat.
// master = the environment (drives in_* and out_ready), slave = the pipeline.
interface reduce_pipe_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 2
);
   import reduce_pipe_pkg::*;

   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*WIDTH-1:0] in_data;
   red_mode_t                 in_mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          out_data;
   red_mode_t                 out_mode;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_mode
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_mode
   );

endinterface

// File: rtl/reduce_pipe_slice.sv
// One elastic register stage (valid + payload + mode); 1 cycle latency.
// Backpressure: ready = ~valid | down_ready, so a bubble is always overwritten and a full stage holds.
module pipe_slice
   import reduce_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  red_mode_t        up_mode,
   input  logic             down_ready,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output red_mode_t        mode
);

   assign ready = ~valid | down_ready;

   // Payload only loads with a real beat, so bubbles never pull undriven input data in.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         mode  <= RED_AND;
      end else if (ready) begin
         valid <= up_valid;
         if (up_valid) begin
            data <= up_data;
            mode <= up_mode;
         end
      end
   end

endmodule

// File: rtl/reduce_pipe.sv
// Captures CHANNELS lanes, reduces them bitwise (AND/OR/XOR) and delays the result; latency STAGES cycles.
// Backpressure: elastic ready chain, bubbles collapse, in_ready falls only when all stages are full and stalled.
module reduce_pipe
   import reduce_pipe_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 2,
   parameter int STAGES   = 2
) (
   input logic           clk,
   input logic           rst,
   reduce_pipe_if.slave  bus
);

   logic [STAGES:1]           vld;
   logic [STAGES+1:1]         rdy;
   red_mode_t                 md  [1:STAGES];
   logic [WIDTH-1:0]          dat [2:STAGES];
   logic [CHANNELS*WIDTH-1:0] cap_dat;

   function automatic logic [WIDTH-1:0] reduce_lanes(input logic [CHANNELS*WIDTH-1:0] lanes,
                                                     input red_mode_t m);
      logic [WIDTH-1:0] r;
      r = lanes[WIDTH-1:0];
      for (int i = 1; i < CHANNELS; i++) begin
         case (m)
            RED_OR:  r = r | lanes[i*WIDTH +: WIDTH];
            RED_XOR: r = r ^ lanes[i*WIDTH +: WIDTH];
            default: r = r & lanes[i*WIDTH +: WIDTH];
         endcase
      end
      return r;
   endfunction

   assign rdy[STAGES+1] = bus.out_ready;

   pipe_slice #(.WIDTH(CHANNELS*WIDTH)) u_capture (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (bus.in_valid),
      .up_data    (bus.in_data),
      .up_mode    (bus.in_mode),
      .down_ready (rdy[2]),
      .ready      (rdy[1]),
      .valid      (vld[1]),
      .data       (cap_dat),
      .mode       (md[1])
   );

   // Stage 2 registers the reduced value; later stages are pure delay.
   for (genvar k = 2; k <= STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] up_d;

      if (k == 2) begin : g_red
         assign up_d = reduce_lanes(cap_dat, md[1]);
      end else begin : g_dly
         assign up_d = dat[k-1];
      end

      pipe_slice #(.WIDTH(WIDTH)) u_slice (
         .clk        (clk),
         .rst        (rst),
         .up_valid   (vld[k-1]),
         .up_data    (up_d),
         .up_mode    (md[k-1]),
         .down_ready (rdy[k+1]),
         .ready      (rdy[k]),
         .valid      (vld[k]),
         .data       (dat[k]),
         .mode       (md[k])
      );
   end

   assign bus.in_ready  = rdy[1];
   assign bus.out_valid = vld[STAGES];
   assign bus.out_data  = dat[STAGES];
   assign bus.out_mode  = md[STAGES];

endmodule

// File: tb/tb_reduce_pipe.sv
// Directed and randomised checks of reduce_pipe across four parameter sets sharing one clock and reset.
module tb_reduce_pipe;
   import reduce_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   reduce_pipe_if #(.WIDTH(8),  .CHANNELS(2)) if_a ();
   reduce_pipe_if #(.WIDTH(8),  .CHANNELS(4)) if_b ();
   reduce_pipe_if #(.WIDTH(8),  .CHANNELS(2)) if_c ();
   reduce_pipe_if #(.WIDTH(16), .CHANNELS(3)) if_d ();

   reduce_pipe #(.WIDTH(8),  .CHANNELS(2), .STAGES(2)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   reduce_pipe #(.WIDTH(8),  .CHANNELS(4), .STAGES(4)) u_b (.clk(clk), .rst(rst), .bus(if_b));
   reduce_pipe #(.WIDTH(8),  .CHANNELS(2), .STAGES(3)) u_c (.clk(clk), .rst(rst), .bus(if_c));
   reduce_pipe #(.WIDTH(16), .CHANNELS(3), .STAGES(3)) u_d (.clk(clk), .rst(rst), .bus(if_d));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref2(input logic [15:0] d, input logic [1:0] m);
      case (m)
         2'b01:   return d[7:0] | d[15:8];
         2'b10:   return d[7:0] ^ d[15:8];
         default: return d[7:0] & d[15:8];
      endcase
   endfunction

   function automatic logic [15:0] ref3(input logic [47:0] d, input logic [1:0] m);
      case (m)
         2'b01:   return d[15:0] | d[31:16] | d[47:32];
         2'b10:   return d[15:0] ^ d[31:16] ^ d[47:32];
         default: return d[15:0] & d[31:16] & d[47:32];
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vectors++;
      if (if_a.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", if_a.out_valid); end
      vectors++;
      if (if_a.out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", if_a.out_data); end
      vectors++;
      if (if_a.out_mode !== RED_AND) begin miscompares++; $display("FAIL reset_out_mode: got %0d want 0", if_a.out_mode); end
      vectors++;
      if (if_a.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", if_a.in_ready); end

      rst = 1'b0;
      if_a.out_ready = 1'b0;
      if_a.in_valid  = 1'b1;
      if_a.in_data   = 16'h3CF0;
      if_a.in_mode   = RED_OR;
      #1;
      vectors++;
      if (if_a.in_ready !== 1'b1 || if_a.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b want 1/0", if_a.in_ready, if_a.out_valid);
      end
      step();
      if_a.in_data = 16'h0102;
      if_a.in_mode = RED_XOR;
      step();
      if_a.in_valid = 1'b0;
      #1;
      vectors++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 8'hFC) begin
         miscompares++;
         $display("FAIL prereset_inflight: got valid=%b data=%h want 1/fc", if_a.out_valid, if_a.out_data);
      end

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (if_a.out_valid !== 1'b0 || if_a.out_data !== 8'h00 || if_a.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midstream_reset[%0d]: got valid=%b data=%h in_ready=%b want 0/00/1",
                     i, if_a.out_valid, if_a.out_data, if_a.in_ready);
         end
      end
      rst = 1'b0;
      if_a.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         vectors++;
         if (if_a.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL discarded_beat[%0d]: got out_valid=%b want 0", i, if_a.out_valid);
         end
         step();
      end
   endtask

   task automatic test_modes();
      logic [7:0] expm [4] = '{8'h30, 8'hFC, 8'hCC, 8'h30};
      int n = 0;
      if_a.out_ready = 1'b1;
      if_a.in_data   = 16'h3CF0;
      for (int j = 0; j < 12; j++) begin
         if_a.in_valid = (j < 4);
         if_a.in_mode  = red_mode_t'(j % 4);
         #1;
         if (if_a.out_valid && n < 4) begin
            vectors++;
            if (if_a.out_data !== expm[n] || if_a.out_mode !== red_mode_t'(n)) begin
               miscompares++;
               $display("FAIL mode_%0d: got data=%h mode=%0d want %h/%0d", n, if_a.out_data, if_a.out_mode, expm[n], n);
            end
            n++;
         end
         step();
      end
      if_a.in_valid = 1'b0;
      vectors++;
      if (n !== 4) begin miscompares++; $display("FAIL mode_count: got %0d want 4", n); end
   endtask

   task automatic test_latency();
      if_b.out_ready = 1'b1;
      if_b.in_data   = 32'h80040201;
      if_b.in_mode   = RED_XOR;
      for (int j = 0; j <= 20; j++) begin
         if_b.in_valid = (j == 10);
         #1;
         vectors++;
         if (if_b.out_valid !== (j == 14)) begin
            miscompares++;
            $display("FAIL latency_valid@%0d: got %b want %b", j, if_b.out_valid, (j == 14));
         end
         if (j == 14) begin
            vectors++;
            if (if_b.out_data !== 8'h87 || if_b.out_mode !== RED_XOR) begin
               miscompares++;
               $display("FAIL latency_data: got %h/%0d want 87/2", if_b.out_data, if_b.out_mode);
            end
         end
         step();
      end
      if_b.in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] d   [20];
      logic [7:0]  exp [20];
      int sent = 0, got = 0, first = -1, last = -1;
      for (int i = 0; i < 20; i++) begin
         d[i]   = {8'(i ^ 8'h5A), 8'(i * 7 + 1)};
         exp[i] = ref2(d[i], 2'(i % 4));
      end
      if_a.out_ready = 1'b1;
      for (int j = 0; j < 40; j++) begin
         if_a.in_valid = (sent < 20);
         if (sent < 20) begin
            if_a.in_data = d[sent];
            if_a.in_mode = red_mode_t'(sent % 4);
         end
         #1;
         if (sent < 20) begin
            vectors++;
            if (if_a.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready@%0d: got %b want 1", j, if_a.in_ready); end
         end
         if (if_a.out_valid) begin
            vectors++;
            if (got >= 20) begin
               miscompares++;
               $display("FAIL b2b_extra: got beat %0d want none", got);
            end else if (if_a.out_data !== exp[got] || if_a.out_mode !== red_mode_t'(got % 4)) begin
               miscompares++;
               $display("FAIL b2b_beat%0d: got %h/%0d want %h/%0d", got, if_a.out_data, if_a.out_mode, exp[got], got % 4);
            end
            if (first < 0) first = j;
            last = j;
            got++;
         end
         if (if_a.in_valid && if_a.in_ready) sent++;
         step();
      end
      if_a.in_valid = 1'b0;
      vectors++;
      if (got !== 20 || last - first !== 19) begin
         miscompares++;
         $display("FAIL b2b_stream: got count=%0d span=%0d want 20/19", got, last - first);
      end
   endtask

   task automatic test_stall();
      logic [15:0] d   [10];
      logic [7:0]  exp [10];
      int sent = 0, got = 0;
      for (int i = 0; i < 10; i++) begin
         d[i]   = {8'(8'hA0 + i), 8'(8'h13 * i + 8'h0F)};
         exp[i] = ref2(d[i], 2'(i % 3));
      end
      for (int j = 0; j < 60; j++) begin
         if_c.out_ready = (j >= 8);
         if_c.in_valid  = (sent < 10);
         if (sent < 10) begin
            if_c.in_data = d[sent];
            if_c.in_mode = red_mode_t'(sent % 3);
         end
         #1;
         if (j >= 3 && j < 8) begin
            vectors++;
            if (if_c.in_ready !== 1'b0 || if_c.out_valid !== 1'b1 || if_c.out_data !== exp[0] || if_c.out_mode !== RED_AND) begin
               miscompares++;
               $display("FAIL stall_hold@%0d: got in_ready=%b valid=%b data=%h want 0/1/%h",
                        j, if_c.in_ready, if_c.out_valid, if_c.out_data, exp[0]);
            end
         end
         if (j == 7) begin
            vectors++;
            if (sent !== 3) begin miscompares++; $display("FAIL stall_accepted: got %0d want 3", sent); end
         end
         if (if_c.out_valid && if_c.out_ready) begin
            vectors++;
            if (got >= 10) begin
               miscompares++;
               $display("FAIL stall_extra: got beat %0d want none", got);
            end else if (if_c.out_data !== exp[got] || if_c.out_mode !== red_mode_t'(got % 3)) begin
               miscompares++;
               $display("FAIL stall_beat%0d: got %h/%0d want %h/%0d", got, if_c.out_data, if_c.out_mode, exp[got], got % 3);
            end
            got++;
         end
         if (if_c.in_valid && if_c.in_ready) sent++;
         step();
      end
      if_c.in_valid = 1'b0;
      vectors++;
      if (got !== 10 || if_c.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_total: got count=%0d valid=%b want 10/0", got, if_c.out_valid);
      end
   endtask

   task automatic test_random();
      logic [15:0] q_d [$];
      logic [1:0]  q_m [$];
      logic [63:0] rnd;
      logic [15:0] prev_d = '0;
      logic [15:0] want_d;
      logic [1:0]  want_m;
      logic        prev_hold = 1'b0;
      int sent = 0, got = 0, cyc = 0;
      while (got < 10000 && cyc < 40000) begin
         rnd            = {$urandom(), $urandom()};
         if_d.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
         if_d.in_data   = rnd[47:0];
         if_d.in_mode   = red_mode_t'($urandom_range(0, 3));
         if_d.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (prev_hold) begin
            vectors++;
            if (if_d.out_valid !== 1'b1 || if_d.out_data !== prev_d) begin
               miscompares++;
               $display("FAIL rand_freeze@%0d: got %b/%h want 1/%h", cyc, if_d.out_valid, if_d.out_data, prev_d);
            end
         end
         if (if_d.in_valid && if_d.in_ready) begin
            q_d.push_back(ref3(if_d.in_data, 2'(if_d.in_mode)));
            q_m.push_back(2'(if_d.in_mode));
            sent++;
         end
         if (if_d.out_valid && if_d.out_ready) begin
            vectors++;
            if (q_d.size() == 0) begin
               miscompares++;
               $display("FAIL rand_spurious@%0d: got %h want no beat", cyc, if_d.out_data);
            end else begin
               want_d = q_d.pop_front();
               want_m = q_m.pop_front();
               if (if_d.out_data !== want_d || 2'(if_d.out_mode) !== want_m) begin
                  miscompares++;
                  $display("FAIL rand_beat%0d: got %h/%0d want %h/%0d", got, if_d.out_data, if_d.out_mode, want_d, want_m);
               end
            end
            got++;
         end
         prev_hold = if_d.out_valid && !if_d.out_ready;
         prev_d    = if_d.out_data;
         cyc++;
         step();
      end
      if_d.in_valid = 1'b0;
      vectors++;
      if (got !== 10000 || q_d.size() !== 0) begin
         miscompares++;
         $display("FAIL rand_total: got %0d beats, %0d pending want 10000/0", got, q_d.size());
      end
   endtask

   initial begin
      rst            = 1'b1;
      if_a.in_valid  = 1'b0; if_a.in_data = '0; if_a.in_mode = RED_AND; if_a.out_ready = 1'b0;
      if_b.in_valid  = 1'b0; if_b.in_data = '0; if_b.in_mode = RED_AND; if_b.out_ready = 1'b0;
      if_c.in_valid  = 1'b0; if_c.in_data = '0; if_c.in_mode = RED_AND; if_c.out_ready = 1'b0;
      if_d.in_valid  = 1'b0; if_d.in_data = '0; if_d.in_mode = RED_AND; if_d.out_ready = 1'b0;
      #1;
      test_reset();
      test_modes();
      test_latency();
      test_back_to_back();
      test_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
